// File: rtl/pmp_checker_seq_if.sv
// Request/response handshake bundle for the sequential PMP checker.
// master: the LSU/PTW side issuing checks; slave: the checker itself.
interface pmp_checker_seq_if #(
  parameter int PADDR_BITS = 34,
  parameter int IDX_W      = 4
);

  logic                  io_req_valid;
  logic                  io_req_ready;
  logic [PADDR_BITS-1:0] io_req_addr;
  logic [1:0]            io_req_size;
  logic [1:0]            io_req_prv;

  logic                  io_resp_valid;
  logic                  io_resp_ready;
  logic                  io_resp_r;
  logic                  io_resp_w;
  logic                  io_resp_x;
  logic                  io_resp_hit;
  logic [IDX_W-1:0]      io_resp_idx;

  modport master (
    output io_req_valid, io_req_addr, io_req_size, io_req_prv, io_resp_ready,
    input  io_req_ready, io_resp_valid, io_resp_r, io_resp_w, io_resp_x,
           io_resp_hit, io_resp_idx
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_req_size, io_req_prv, io_resp_ready,
    output io_req_ready, io_resp_valid, io_resp_r, io_resp_w, io_resp_x,
           io_resp_hit, io_resp_idx
  );

endinterface

// File: rtl/pmp_checker_seq.sv
// Sequential PMP checker: scans NUM_ENTRIES entries ENTRIES_PER_CYCLE at a
// time in priority order (lowest index wins) and returns R/W/X permission for
// one captured access. PMP configuration is read live; a CSR write pulse
// during a scan restarts it from group 0.
// Optional feature: define PMP_MISALIGN_COUNT_EN to add io_misalign_count, a
// saturating count of accepted responses that hit a misaligned access.
module pmp_checker_seq #(
  parameter int NUM_ENTRIES       = 16,
  parameter int PADDR_BITS        = 34,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  pmp_checker_seq_if.slave                      bus,
  input  logic [8*NUM_ENTRIES-1:0]              io_pmp_cfg,
  input  logic [(PADDR_BITS-2)*NUM_ENTRIES-1:0] io_pmp_addr,
  input  logic [PADDR_BITS*NUM_ENTRIES-1:0]     io_pmp_mask,
  input  logic                                  io_pmp_update
`ifdef PMP_MISALIGN_COUNT_EN
  ,
  output logic [15:0]                           io_misalign_count
`endif
);

  localparam int G     = (NUM_ENTRIES + ENTRIES_PER_CYCLE - 1) / ENTRIES_PER_CYCLE;
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
  localparam int PA_W  = PADDR_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Evaluate one entry: returns {hit, aligned}. Bounds are compared at
  // PADDR_BITS+1 so addr+lsb can never wrap.
  function automatic logic [1:0] entry_eval(
    input logic [7:0]            cfg,
    input logic [PA_W-1:0]       pa,
    input logic [PA_W-1:0]       prev_pa,
    input logic                  first,
    input logic [PADDR_BITS-1:0] mask,
    input logic [PADDR_BITS-1:0] addr,
    input logic [PADDR_BITS-1:0] lsb
  );
    logic [PADDR_BITS-1:0] base;
    logic [PADDR_BITS-1:0] bottom;
    logic [PADDR_BITS:0]   addr_x;
    logic [PADDR_BITS:0]   end_x;
    logic [PADDR_BITS:0]   bottom_x;
    logic [PADDR_BITS:0]   top_x;
    logic                  hit;
    logic                  aligned;
    base     = {pa, 2'b00};
    bottom   = first ? {PADDR_BITS{1'b0}} : {prev_pa, 2'b00};
    addr_x   = {1'b0, addr};
    end_x    = addr_x + {1'b0, lsb};
    bottom_x = {1'b0, bottom};
    top_x    = {1'b0, base};
    case (cfg[4:3])
      2'b01: begin
        hit     = (bottom <= addr) && (addr < base);
        aligned = !((bottom_x > addr_x) && (bottom_x <= end_x)) &&
                  !((top_x > addr_x) && (top_x <= end_x));
      end
      2'b10, 2'b11: begin
        hit     = ((addr ^ base) & ~(mask | lsb)) == {PADDR_BITS{1'b0}};
        aligned = (lsb[2:0] & ~mask[2:0]) == 3'b000;
      end
      default: begin
        hit     = 1'b0;
        aligned = 1'b0;
      end
    endcase
    return {hit, aligned};
  endfunction

  // Unpacked views of the flat PMP buses
  logic [7:0]            cfg_a  [NUM_ENTRIES];
  logic [PA_W-1:0]       pa_a   [NUM_ENTRIES];
  logic [PADDR_BITS-1:0] mask_a [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] unused_cfg_s;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_unpack
    assign cfg_a[gi]        = io_pmp_cfg[8*gi +: 8];
    assign pa_a[gi]         = io_pmp_addr[PA_W*gi +: PA_W];
    assign mask_a[gi]       = io_pmp_mask[PADDR_BITS*gi +: PADDR_BITS];
    assign unused_cfg_s[gi] = ^cfg_a[gi][6:5];
  end

  state_e                state_q, state_d;
  logic [GRP_W-1:0]      g_q, g_d;
  logic [PADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  prv_m_q, prv_m_d;
  logic                  req_ready_q, resp_valid_q;
  logic                  resp_r_q, resp_r_d;
  logic                  resp_w_q, resp_w_d;
  logic                  resp_x_q, resp_x_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [IDX_W-1:0]      resp_idx_q, resp_idx_d;
  logic                  resp_misal_q, resp_misal_d;

  logic [PADDR_BITS-1:0] lsb_s;
  logic                  grp_hit_s;
  logic                  grp_aligned_s;
  logic [IDX_W-1:0]      grp_idx_s;
  logic                  grp_lock_s;
  logic [2:0]            grp_xwr_s;
  logic                  last_grp_s;
  logic                  ignore_s;

  // Byte-offset mask of the access derived from its size
  always_comb begin
    case (size_q)
      2'd0:    lsb_s = {PADDR_BITS{1'b0}};
      2'd1:    lsb_s = PADDR_BITS'(1);
      2'd2:    lsb_s = PADDR_BITS'(3);
      default: lsb_s = PADDR_BITS'(7);
    endcase
  end

  // Evaluate the current group; first hitting entry (lowest index) wins
  always_comb begin
    int         ent_v;
    int         prev_v;
    logic [1:0] ev_v;
    grp_hit_s     = 1'b0;
    grp_aligned_s = 1'b0;
    grp_idx_s     = {IDX_W{1'b0}};
    grp_lock_s    = 1'b0;
    grp_xwr_s     = 3'b000;
    ent_v         = 0;
    prev_v        = 0;
    ev_v          = 2'b00;
    for (int k = 0; k < ENTRIES_PER_CYCLE; k++) begin
      ent_v  = int'(g_q) * ENTRIES_PER_CYCLE + k;
      prev_v = (ent_v > 0) ? ent_v - 1 : 0;
      if (!grp_hit_s && (ent_v < NUM_ENTRIES)) begin
        ev_v = entry_eval(cfg_a[IDX_W'(ent_v)], pa_a[IDX_W'(ent_v)],
                          pa_a[IDX_W'(prev_v)], (ent_v == 0),
                          mask_a[IDX_W'(ent_v)], addr_q, lsb_s);
        if (ev_v[1]) begin
          grp_hit_s     = 1'b1;
          grp_aligned_s = ev_v[0];
          grp_idx_s     = IDX_W'(ent_v);
          grp_lock_s    = cfg_a[IDX_W'(ent_v)][7];
          grp_xwr_s     = cfg_a[IDX_W'(ent_v)][2:0];
        end else begin
          grp_hit_s = 1'b0;
        end
      end else begin
        ev_v = 2'b00;
      end
    end
  end

  assign last_grp_s = (g_q == GRP_W'(G - 1));
  assign ignore_s   = prv_m_q && !grp_lock_s;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a CSR update in SCAN overrides any hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.io_req_valid) state_d = ST_SCAN;
        else                  state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (io_pmp_update)                state_d = ST_SCAN;
        else if (grp_hit_s || last_grp_s) state_d = ST_RESP;
        else                              state_d = ST_SCAN;
      end
      ST_RESP: begin
        if (bus.io_resp_ready) state_d = ST_IDLE;
        else                   state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: request capture, group stepping, result formation
  always_comb begin
    g_d          = g_q;
    addr_d       = addr_q;
    size_d       = size_q;
    prv_m_d      = prv_m_q;
    resp_r_d     = resp_r_q;
    resp_w_d     = resp_w_q;
    resp_x_d     = resp_x_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_misal_d = resp_misal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.io_req_valid) begin
          g_d     = {GRP_W{1'b0}};
          addr_d  = bus.io_req_addr;
          size_d  = bus.io_req_size;
          prv_m_d = bus.io_req_prv[1];
        end else begin
          g_d = {GRP_W{1'b0}};
        end
      end
      ST_SCAN: begin
        if (io_pmp_update) begin
          g_d = {GRP_W{1'b0}};
        end else if (grp_hit_s) begin
          resp_r_d     = grp_aligned_s && (grp_xwr_s[0] || ignore_s);
          resp_w_d     = grp_aligned_s && (grp_xwr_s[1] || ignore_s);
          resp_x_d     = grp_aligned_s && (grp_xwr_s[2] || ignore_s);
          resp_hit_d   = 1'b1;
          resp_idx_d   = grp_idx_s;
          resp_misal_d = !grp_aligned_s;
        end else if (last_grp_s) begin
          resp_r_d     = prv_m_q;
          resp_w_d     = prv_m_q;
          resp_x_d     = prv_m_q;
          resp_hit_d   = 1'b0;
          resp_idx_d   = {IDX_W{1'b0}};
          resp_misal_d = 1'b0;
        end else begin
          g_d = g_q + GRP_W'(1);
        end
      end
      ST_RESP: begin
        g_d = g_q;
      end
      default: begin
        g_d = {GRP_W{1'b0}};
      end
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      g_q          <= {GRP_W{1'b0}};
      addr_q       <= {PADDR_BITS{1'b0}};
      size_q       <= 2'b00;
      prv_m_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_r_q     <= 1'b0;
      resp_w_q     <= 1'b0;
      resp_x_q     <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= {IDX_W{1'b0}};
      resp_misal_q <= 1'b0;
    end else begin
      g_q          <= g_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      prv_m_q      <= prv_m_d;
      req_ready_q  <= (state_d == ST_IDLE);
      resp_valid_q <= (state_d == ST_RESP);
      resp_r_q     <= resp_r_d;
      resp_w_q     <= resp_w_d;
      resp_x_q     <= resp_x_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_misal_q <= resp_misal_d;
    end
  end

  assign bus.io_req_ready  = req_ready_q;
  assign bus.io_resp_valid = resp_valid_q;
  assign bus.io_resp_r     = resp_r_q;
  assign bus.io_resp_w     = resp_w_q;
  assign bus.io_resp_x     = resp_x_q;
  assign bus.io_resp_hit   = resp_hit_q;
  assign bus.io_resp_idx   = resp_idx_q;

`ifdef PMP_MISALIGN_COUNT_EN
  logic [15:0] mis_cnt_q, mis_cnt_d;

  // Next misalign count: +1 per accepted misaligned hit, saturating
  always_comb begin
    if (resp_valid_q && bus.io_resp_ready && resp_hit_q && resp_misal_q &&
        (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Misalign counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      mis_cnt_q <= 16'd0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign io_misalign_count = mis_cnt_q;

  logic unused_s;
  assign unused_s = ^{unused_cfg_s, bus.io_req_prv[0]};
`else
  logic unused_s;
  assign unused_s = ^{unused_cfg_s, bus.io_req_prv[0], resp_misal_q};
`endif

endmodule

// File: tb/tb_pmp_checker_seq.sv
// Scoreboard bench for pmp_checker_seq (16 entries, 4 per cycle, 34-bit PA).
module tb_pmp_checker_seq;

  localparam int N  = 16;
  localparam int PB = 34;
  localparam int E  = 4;
  localparam int G  = 4;
  localparam int IW = 4;

  logic clock;
  logic reset;
  logic [8*N-1:0]      pmp_cfg;
  logic [(PB-2)*N-1:0] pmp_addr;
  logic [PB*N-1:0]     pmp_mask;
  logic                pmp_update;
`ifdef PMP_MISALIGN_COUNT_EN
  logic [15:0]         misalign_count;
`endif

  logic [7:0]  cfg_t  [N];
  logic [31:0] pa_t   [N];
  logic [33:0] mask_t [N];

  pmp_checker_seq_if #(.PADDR_BITS(PB), .IDX_W(IW)) bus ();

  pmp_checker_seq #(.NUM_ENTRIES(N), .PADDR_BITS(PB), .ENTRIES_PER_CYCLE(E)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .io_pmp_cfg    (pmp_cfg),
    .io_pmp_addr   (pmp_addr),
    .io_pmp_mask   (pmp_mask),
    .io_pmp_update (pmp_update)
`ifdef PMP_MISALIGN_COUNT_EN
    ,
    .io_misalign_count (misalign_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    pmp_cfg  = '0;
    pmp_addr = '0;
    pmp_mask = '0;
    for (int i = 0; i < N; i++) begin
      pmp_cfg[8*i +: 8]        = cfg_t[i];
      pmp_addr[(PB-2)*i +: 32] = pa_t[i];
      pmp_mask[PB*i +: PB]     = mask_t[i];
    end
  end

  typedef struct {
    logic          r;
    logic          w;
    logic          x;
    logic          hit;
    logic [IW-1:0] idx;
    logic          misal;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  bit   hold_ready = 1'b0;

  // Reference: first matching entry over the whole table, latency by group
  function automatic exp_t model(logic [33:0] addr, logic [1:0] size, logic [1:0] prv);
    exp_t e;
    longint unsigned a, lsb, bot, top, base, m;
    bit hit, al, ign;
    a = 64'(addr);
    lsb = (64'd1 << size) - 64'd1;
    e.r = prv[1]; e.w = prv[1]; e.x = prv[1];
    e.hit = 1'b0; e.idx = '0; e.misal = 1'b0; e.lat = G + 1; e.acc = 0;
    for (int i = 0; i < N; i++) begin
      hit = 1'b0; al = 1'b0;
      if (cfg_t[i][4:3] == 2'b01) begin
        bot = 64'd0;
        if (i > 0) bot = 64'(pa_t[i-1]) * 64'd4;
        top = 64'(pa_t[i]) * 64'd4;
        hit = (bot <= a) && (a < top);
        al  = !((bot > a) && (bot <= a + lsb)) && !((top > a) && (top <= a + lsb));
      end else if (cfg_t[i][4:3] != 2'b00) begin
        base = 64'(pa_t[i]) * 64'd4;
        m    = 64'(mask_t[i]);
        hit  = ((a ^ base) & ~(m | lsb)) == 64'd0;
        al   = (lsb & ~m & 64'd7) == 64'd0;
      end
      if (hit) begin
        ign     = prv[1] && !cfg_t[i][7];
        e.r     = al && (cfg_t[i][0] || ign);
        e.w     = al && (cfg_t[i][1] || ign);
        e.x     = al && (cfg_t[i][2] || ign);
        e.hit   = 1'b1;
        e.idx   = IW'(i);
        e.misal = !al;
        e.lat   = i / E + 2;
        return e;
      end
    end
    return e;
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_t[i] = 8'h00; pa_t[i] = 32'h0; mask_t[i] = 34'h0;
    end
  endtask

  task automatic set_entry(int i, logic [7:0] c, logic [31:0] pa, logic [33:0] m);
    cfg_t[i] = c; pa_t[i] = pa; mask_t[i] = m;
  endtask

  task automatic rand_cfg();
    logic [1:0]  a;
    logic [33:0] base;
    int k;
    for (int i = 0; i < N; i++) begin
      a = 2'($urandom_range(0, 3));
      cfg_t[i] = {1'($urandom_range(0, 1)), 2'b00, a, 3'($urandom_range(0, 7))};
      base = 34'($urandom_range(0, 'h8FFF));
      case (a)
        2'b11: begin
          k = $urandom_range(3, 13);
          mask_t[i] = (34'h1 << k) - 34'h1;
          pa_t[i] = 32'((base & ~mask_t[i]) >> 2);
        end
        2'b10: begin
          mask_t[i] = 34'h3;
          pa_t[i] = 32'(base >> 2);
        end
        default: begin
          mask_t[i] = 34'h0;
          pa_t[i] = 32'($urandom_range(0, 'h2400));
        end
      endcase
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    @(posedge clock); #1;
    while (!bus.io_req_ready && w < 300) begin
      @(posedge clock); #1;
      w++;
    end
    n_tests++;
    if (!bus.io_req_ready) begin
      n_fail++;
      $display("FAIL req_ready_timeout: ready=%0b required=1", bus.io_req_ready);
    end
  endtask

  task automatic issue(logic [33:0] addr, logic [1:0] size, logic [1:0] prv, output int acc);
    bus.io_req_valid = 1'b1;
    bus.io_req_addr  = addr;
    bus.io_req_size  = size;
    bus.io_req_prv   = prv;
    @(posedge clock); #1;
    acc = cyc;
    bus.io_req_valid = 1'b0;
    bus.io_req_addr  = $urandom();
  endtask

  task automatic push_exp(logic [33:0] addr, logic [1:0] size, logic [1:0] prv, int acc, int extra);
    exp_t e;
    e = model(addr, size, prv);
    e.acc = acc;
    e.lat = e.lat + extra;
    sb_q.push_back(e);
  endtask

  task automatic send(logic [33:0] addr, logic [1:0] size, logic [1:0] prv);
    int acc;
    issue(addr, size, prv, acc);
    push_exp(addr, size, prv, acc, 0);
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!bus.io_resp_valid && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    n_tests++;
    if (!bus.io_resp_valid) begin
      n_fail++;
      $display("FAIL resp_valid_timeout: valid=%0b required=1", bus.io_resp_valid);
    end
  endtask

  // Pops an expectation per response handshake; checks held outputs every valid cycle
  task automatic monitor_loop();
    exp_t e;
    bit seen = 1'b0;
    int first = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        seen = 1'b0;
        exp_cnt = 0;
      end else begin
`ifdef PMP_MISALIGN_COUNT_EN
        n_tests++;
        if (int'(misalign_count) != exp_cnt) begin
          n_fail++;
          $display("FAIL misalign_count: got %0d required %0d", misalign_count, exp_cnt);
        end
`endif
        if (bus.io_resp_valid) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: valid=1 with no outstanding request");
          end else begin
            e = sb_q[0];
            if (!seen) begin
              seen = 1'b1;
              first = cyc;
            end
            if ({bus.io_resp_r, bus.io_resp_w, bus.io_resp_x, bus.io_resp_hit, bus.io_resp_idx} !==
                {e.r, e.w, e.x, e.hit, e.idx}) begin
              n_fail++;
              $display("FAIL resp_fields: got rwx=%b%b%b hit=%b idx=%0d required rwx=%b%b%b hit=%b idx=%0d",
                       bus.io_resp_r, bus.io_resp_w, bus.io_resp_x, bus.io_resp_hit, bus.io_resp_idx,
                       e.r, e.w, e.x, e.hit, e.idx);
            end
            if (bus.io_resp_ready) begin
              n_tests++;
              if (first - e.acc + 1 != e.lat) begin
                n_fail++;
                $display("FAIL resp_latency: got %0d required %0d", first - e.acc + 1, e.lat);
              end
              void'(sb_q.pop_front());
              seen = 1'b0;
              if (e.hit && e.misal && exp_cnt < 65535) exp_cnt++;
            end
          end
        end
      end
    end
  endtask

  // Consumer ready: random back-pressure unless held low
  task automatic ready_loop();
    forever begin
      @(posedge clock); #1;
      if (hold_ready) bus.io_resp_ready = 1'b0;
      else            bus.io_resp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int acc;
    int w;
    logic [33:0] ra;
    logic [1:0]  rs, rp;

    reset = 1'b1;
    pmp_update = 1'b0;
    bus.io_req_valid  = 1'b0;
    bus.io_req_addr   = '0;
    bus.io_req_size   = 2'b00;
    bus.io_req_prv    = 2'b00;
    bus.io_resp_ready = 1'b0;
    clear_cfg();

    fork
      monitor_loop();
      ready_loop();
    join_none

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if ({bus.io_req_ready, bus.io_resp_valid, bus.io_resp_r, bus.io_resp_w, bus.io_resp_x,
         bus.io_resp_hit, bus.io_resp_idx} !== {1'b1, 5'b00000, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b rwx=%b%b%b hit=%b idx=%0d required ready=1 others 0",
               bus.io_req_ready, bus.io_resp_valid, bus.io_resp_r, bus.io_resp_w, bus.io_resp_x,
               bus.io_resp_hit, bus.io_resp_idx);
    end

    // NAPOT 4 KiB at 0x8000_0000, RWX, user mode
    wait_ready(); clear_cfg();
    set_entry(0, 8'h1F, 32'h2000_0000, 34'hFFF);
    send(34'h0_8000_0010, 2'd3, 2'd0);

    // TOR [0x1000,0x2000) R-only at entry 9, aligned then straddling the top
    wait_ready(); clear_cfg();
    set_entry(8, 8'h00, 32'h400, 34'h0);
    set_entry(9, 8'h09, 32'h800, 34'h0);
    send(34'h1FF8, 2'd3, 2'd0);
    wait_ready();
    send(34'h1FFC, 2'd3, 2'd0);

    // Nothing enabled: M-mode gets full access, U-mode none
    wait_ready(); clear_cfg();
    send(34'h1234, 2'd2, 2'd3);
    wait_ready();
    send(34'h1234, 2'd2, 2'd0);

    // CSR update in the second scan cycle restarts with the new table
    wait_ready(); clear_cfg();
    issue(34'h1FF8, 2'd3, 2'd0, acc);
    @(posedge clock); #1;
    pmp_update = 1'b1;
    set_entry(8, 8'h00, 32'h400, 34'h0);
    set_entry(9, 8'h09, 32'h800, 34'h0);
    push_exp(34'h1FF8, 2'd3, 2'd0, acc, 2);
    @(posedge clock); #1;
    pmp_update = 1'b0;

    // CSR update while a response is held leaves it untouched
    wait_ready(); clear_cfg();
    hold_ready = 1'b1;
    set_entry(0, 8'h1F, 32'h2000_0000, 34'hFFF);
    send(34'h0_8000_0ff8, 2'd3, 2'd0);
    wait_valid();
    pmp_update = 1'b1;
    clear_cfg();
    @(posedge clock); #1;
    pmp_update = 1'b0;
    repeat (3) @(posedge clock);
    hold_ready = 1'b0;

    // Stalled response dropped by reset; next request completes normally
    wait_ready(); clear_cfg();
    hold_ready = 1'b1;
    set_entry(2, 8'h1B, 32'h0000_0400, 34'hFF);
    send(34'h1010, 2'd1, 2'd0);
    wait_valid();
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    sb_q.delete();
    @(posedge clock); #1;
    n_tests++;
    if (bus.io_resp_valid !== 1'b0 || bus.io_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort: got valid=%b ready=%b required valid=0 ready=1",
               bus.io_resp_valid, bus.io_req_ready);
    end
    reset = 1'b0;
    hold_ready = 1'b0;
    wait_ready();
    send(34'h1010, 2'd1, 2'd0);

    // Randomised tables and accesses
    for (int t = 0; t < 200; t++) begin
      wait_ready();
      rand_cfg();
      if ($urandom_range(0, 7) == 0) ra = 34'h3_FFFF_FFF8 + 34'($urandom_range(0, 7));
      else                           ra = 34'($urandom_range(0, 'h9000));
      rs = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 3));
      send(ra, rs, rp);
    end

    wait_ready();
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
    end
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_checker_seq.md
Name: pmp_checker_seq

Overview:
- Parametrised, sequential successor to the combinational 8-entry PMP checker.
- Evaluates NUM_ENTRIES PMP entries against one physical access, ENTRIES_PER_CYCLE entries per cycle, in strict priority order (lowest index wins).
- Request and response use valid/ready handshakes.
- Sits between the LSU/PTW request path and the fault logic, where a fully parallel 16+ entry check does not meet timing.

Parameters:
- NUM_ENTRIES, 16, number of PMP entries (1..64).
- PADDR_BITS, 34, physical address width. PMP address registers are PADDR_BITS-2 bits wide (4-byte granule).
- ENTRIES_PER_CYCLE, 4, entries evaluated per scan cycle (1..NUM_ENTRIES).
- Derived constants: G = ceil(NUM_ENTRIES/ENTRIES_PER_CYCLE); IDX_W = max(1, clog2(NUM_ENTRIES)).

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  1  request valid.
- io_req_ready  out  1  high only in IDLE.
- io_req_addr  in  PADDR_BITS  access byte address.
- io_req_size  in  2  log2 of access bytes (0..3).
- io_req_prv  in  2  privilege level; bit 1 set means M-mode.
- io_pmp_cfg  in  8*NUM_ENTRIES  per entry i at bits [8i+7:8i]: bit 7 L, bits 4:3 A, bit 2 X, bit 1 W, bit 0 R.
- io_pmp_addr  in  (PADDR_BITS-2)*NUM_ENTRIES  pmpaddr per entry.
- io_pmp_mask  in  PADDR_BITS*NUM_ENTRIES  precomputed NAPOT byte mask per entry.
- io_pmp_update  in  1  one-cycle pulse: CSR write to any PMP entry.
- io_resp_valid  out  1  response valid.
- io_resp_ready  in  1  consumer accepts the response.
- io_resp_r / io_resp_w / io_resp_x  out  1 each  permissions granted.
- io_resp_hit  out  1  some entry matched.
- io_resp_idx  out  IDX_W  index of the matching entry; 0 when there is no hit.

Behaviour:
- Request capture: addr, size and prv are registered on the cycle io_req_valid && io_req_ready. PMP inputs are read live every cycle and are not snapshotted.
- FSM states:
  - IDLE -> SCAN on request accept; group counter cleared to 0.
  - SCAN: evaluate entries [g*E, g*E+E-1]; indices >= NUM_ENTRIES never hit.
  - SCAN -> RESP when any entry in group g hits (lowest hit index in the group is chosen), or when g = G-1.
  - SCAN -> SCAN with g+1 otherwise.
  - RESP holds all outputs stable until io_resp_ready; then -> IDLE. Back-to-back throughput: one request per (scan cycles + 2) cycles. There is no IDLE bypass.
- Latency: request accepted in cycle 0. A hit in group g gives io_resp_valid in cycle g+2. No hit gives io_resp_valid in cycle G+1.
- Matching per entry i, with lsb = (1<<size)-1:
  - A=00: off, never hits.
  - A=11 (NAPOT): hit iff ((addr ^ {pmpaddr_i,2'b00}) & ~(mask_i | lsb)) == 0.
    - aligned iff (lsb & ~mask_i[2:0]) == 0.
  - A=01 (TOR): bottom = {pmpaddr_{i-1},2'b00}; bottom = 0 for entry 0. top = {pmpaddr_i,2'b00}.
    - hit iff bottom <= addr < top.
    - aligned iff neither bound lies strictly inside (addr, addr+lsb].
  - A=10 (NA4): treated as NAPOT with mask_i as supplied.
  - TOR lookback crosses group boundaries (entry 4 uses entry 3 even when E=4).
- Permission: ignore = prv[1] && !L.
  - On hit: r = aligned && (R || ignore); same for W and X.
  - No hit: r = w = x = prv[1]; io_resp_hit = 0; io_resp_idx = 0.
- io_pmp_update during SCAN: restart at g = 0 on the next cycle. Latency is extended; the result reflects the new config.
- io_pmp_update in IDLE or RESP: no effect. A held response is not recomputed.
- Update coincident with a hit in SCAN: the restart wins and the hit is discarded.
- Reset values: state IDLE; io_req_ready = 1 after reset deasserts; io_resp_valid, io_resp_r/w/x, io_resp_hit = 0; io_resp_idx = 0; group counter = 0.
- Reset mid-SCAN or mid-RESP aborts the operation; the pending response is dropped.
- io_req_valid while not in IDLE is ignored (ready = 0).
- Unsigned compares throughout, at full PADDR_BITS width. No overflow in addr+lsb: compute with a PADDR_BITS+1 width.

Optional Feature:
- Macro: PMP_MISALIGN_COUNT_EN.
- Defined: adds output io_misalign_count [15:0]. It increments by 1 on each response handshake (io_resp_valid && io_resp_ready) where hit = 1 and aligned = 0. It saturates at 16'hFFFF and is reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Entry 0 NAPOT 0x8000_0000/4KB RWX, L=0, prv=0; addr 0x8000_0010, size 3 -> resp cycle 2; r=w=x=1, hit=1, idx=0.
- Entry 9 only, TOR [0x1000,0x2000) R-only, entry 8 addr 0x400 (0x1000 bytes); addr 0x1FF8, size 3, E=4 -> resp cycle 4; r=1, w=0, x=0, idx=9.
- TOR straddle: same config, addr 0x1FFC, size 3 -> hit=1, r=w=x=0 (misaligned). With PMP_MISALIGN_COUNT_EN the count becomes 1.
- No entries enabled: prv=3 -> r=w=x=1, hit=0, resp cycle G+1=5; prv=0 -> r=w=x=0.
- io_pmp_update pulse in cycle 2 of a 4-group scan -> scan restarts; resp delayed by 2 cycles; result matches the new config. Same pulse while in RESP -> outputs unchanged.
- Hold io_resp_ready=0 for 10 cycles, then assert reset -> io_resp_valid=0 and io_req_ready=1 the next cycle; a new request completes normally.
